// File: rtl/rf_wb_arbiter.sv
// Writeback scheduler: two in-order pipe lanes plus a queued long-latency source onto two regfile ports.
// Latency: pipe writes and FIFO head are combinational to rfw; pushes drain one cycle later at the earliest. Backpressure: l_ready drops when the FIFO is full, pipe lanes never stall.
module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_wen,
  input  logic [AW-1:0]             a_addr,
  input  logic [DW-1:0]             a_wd,
  input  logic                      b_wen,
  input  logic [AW-1:0]             b_addr,
  input  logic [DW-1:0]             b_wd,
  input  logic                      l_valid,
  output logic                      l_ready,
  input  logic [AW-1:0]             l_addr,
  input  logic [DW-1:0]             l_wd,
  output logic [1:0][AW+DW:0]       rfw,
  output logic [(1<<AW)-1:0]        pend_mask,
  output logic [$clog2(DEPTH):0]    fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  logic             a_we, b_we, push;
  logic [1:0]       pop_n;
  logic [AW+DW:0]   pipe_a, pipe_b, head_w, next_w;
  logic [1:0][AW+DW:0] rfw_raw;

  always_comb begin
    a_we   = a_wen && (a_addr != '0);
    b_we   = b_wen && (b_addr != '0);
    pipe_a = {1'b1, a_addr, a_wd};
    pipe_b = {1'b1, b_addr, b_wd};
    rd_nxt = rd_ptr_q + PW'(1);
    // Squashed entries still occupy a drain slot, just with wen low.
    head_w = {vld_q[rd_ptr_q] && (cnt_q != '0), addr_q[rd_ptr_q], data_q[rd_ptr_q]};
    next_w = {vld_q[rd_nxt] && (cnt_q >= CW'(2)), addr_q[rd_nxt], data_q[rd_nxt]};
    rfw_raw = '0;
    pop_n   = 2'd0;
    case ({a_we, b_we})
      2'b11: begin
        rfw_raw[1] = pipe_a;
        rfw_raw[0] = pipe_b;
      end
      2'b10: begin
        rfw_raw[1] = head_w;
        rfw_raw[0] = pipe_a;
        pop_n      = (cnt_q != '0) ? 2'd1 : 2'd0;
      end
      2'b01: begin
        rfw_raw[1] = head_w;
        rfw_raw[0] = pipe_b;
        pop_n      = (cnt_q != '0) ? 2'd1 : 2'd0;
      end
      default: begin
        rfw_raw[1] = head_w;
        rfw_raw[0] = next_w;
        pop_n      = (cnt_q >= CW'(2)) ? 2'd2 : ((cnt_q != '0) ? 2'd1 : 2'd0);
      end
    endcase
    rfw = rfw_raw;
    if (!reset) begin
      rfw[1][AW+DW] = 1'b0;
      rfw[0][AW+DW] = 1'b0;
    end
  end

  assign l_ready  = reset && (cnt_q != CW'(DEPTH));
  assign push     = l_valid && l_ready && (l_addr != '0);
  assign fifo_cnt = cnt_q;

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((a_we && (a_addr == addr_q[i])) || (b_we && (b_addr == addr_q[i])))
        vld_d[i] = 1'b0;
    end
    if (pop_n != 2'd0) vld_d[rd_ptr_q] = 1'b0;
    if (pop_n == 2'd2) vld_d[rd_nxt]   = 1'b0;
    // The write slot is free whenever push is possible, so the new entry overrides any squash.
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      addr_d[wr_ptr_q] = l_addr;
      data_d[wr_ptr_q] = l_wd;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push);
    cnt_d    = cnt_q + CW'(push) - CW'(pop_n);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[addr_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter with a small regfile model fed from rfw.
module tb_rf_wb_arbiter;

  typedef logic [37:0] pt_t;

  typedef struct {
    pt_t         a;
    pt_t         b;
    pt_t         l;
    pt_t         e1;
    pt_t         e0;
    logic [2:0]  ecnt;
    logic        erdy;
    logic [31:0] epend;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             a_wen, b_wen, l_valid, l_ready;
  logic [4:0]       a_addr, b_addr, l_addr;
  logic [31:0]      a_wd, b_wd, l_wd;
  logic [1:0][37:0] rfw;
  logic [31:0]      pend_mask;
  logic [2:0]       fifo_cnt;

  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;
  vec_t vecs [26];

  rf_wb_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .a_wen(a_wen), .a_addr(a_addr), .a_wd(a_wd),
    .b_wen(b_wen), .b_addr(b_addr), .b_wd(b_wd),
    .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_wd(l_wd),
    .rfw(rfw), .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pt_t pw(input logic w, input logic [4:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input pt_t a, input pt_t b, input pt_t l);
    a_wen = a[37]; a_addr = a[36:32]; a_wd = a[31:0];
    b_wen = b[37]; b_addr = b[36:32]; b_wd = b[31:0];
    l_valid = l[37]; l_addr = l[36:32]; l_wd = l[31:0];
  endtask

  task automatic chk_port(input string nm, input pt_t act, input pt_t exp);
    chk({nm, ".wen"}, 64'(act[37]), 64'(exp[37]));
    if (exp[37]) chk({nm, ".ad"}, 64'(act[36:0]), 64'(exp[36:0]));
  endtask

  task automatic rf_apply();
    if (rfw[1][37]) rf[rfw[1][36:32]] = rfw[1][31:0];
    if (rfw[0][37]) rf[rfw[0][36:32]] = rfw[0][31:0];
  endtask

  task automatic run_vec(input int k, input vec_t v);
    @(negedge clk);
    drive(v.a, v.b, v.l);
    #1;
    chk_port($sformatf("v%0d.rfw1", k), rfw[1], v.e1);
    chk_port($sformatf("v%0d.rfw0", k), rfw[0], v.e0);
    chk($sformatf("v%0d.cnt", k), 64'(fifo_cnt), 64'(v.ecnt));
    chk($sformatf("v%0d.rdy", k), 64'(l_ready), 64'(v.erdy));
    chk($sformatf("v%0d.pend", k), 64'(pend_mask), 64'(v.epend));
    rf_apply();
  endtask

  initial begin
    pt_t n, a10, b11;
    n   = '0;
    a10 = pw(1, 10, 32'hA0);
    b11 = pw(1, 11, 32'hB0);
    for (int i = 0; i < 32; i++) rf[i] = '0;

    vecs[0]  = '{n, n, pw(1, 5, 32'h11), n, n, 3'd0, 1'b1, 32'h0};
    vecs[1]  = '{n, n, n, pw(1, 5, 32'h11), n, 3'd1, 1'b1, 32'h20};
    vecs[2]  = '{n, n, n, n, n, 3'd0, 1'b1, 32'h0};
    vecs[3]  = '{a10, b11, pw(1, 1, 32'h101), a10, b11, 3'd0, 1'b1, 32'h0};
    vecs[4]  = '{a10, b11, pw(1, 2, 32'h102), a10, b11, 3'd1, 1'b1, 32'h2};
    vecs[5]  = '{a10, b11, pw(1, 3, 32'h103), a10, b11, 3'd2, 1'b1, 32'h6};
    vecs[6]  = '{a10, b11, pw(1, 4, 32'h104), a10, b11, 3'd3, 1'b1, 32'hE};
    vecs[7]  = '{a10, b11, pw(1, 6, 32'h106), a10, b11, 3'd4, 1'b0, 32'h1E};
    vecs[8]  = '{n, n, n, pw(1, 1, 32'h101), pw(1, 2, 32'h102), 3'd4, 1'b0, 32'h1E};
    vecs[9]  = '{n, n, n, pw(1, 3, 32'h103), pw(1, 4, 32'h104), 3'd2, 1'b1, 32'h18};
    vecs[10] = '{n, n, n, n, n, 3'd0, 1'b1, 32'h0};
    vecs[11] = '{n, n, pw(1, 7, 32'hAA), n, n, 3'd0, 1'b1, 32'h0};
    vecs[12] = '{pw(1, 12, 32'hC0), pw(1, 7, 32'hBB), n, pw(1, 12, 32'hC0), pw(1, 7, 32'hBB), 3'd1, 1'b1, 32'h80};
    vecs[13] = '{n, n, n, n, n, 3'd1, 1'b1, 32'h0};
    vecs[14] = '{n, pw(1, 9, 32'h90), pw(1, 9, 32'h99), n, pw(1, 9, 32'h90), 3'd0, 1'b1, 32'h0};
    vecs[15] = '{n, n, n, pw(1, 9, 32'h99), n, 3'd1, 1'b1, 32'h200};
    vecs[16] = '{n, n, pw(1, 3, 32'h1), n, n, 3'd0, 1'b1, 32'h0};
    vecs[17] = '{pw(1, 3, 32'h33), n, n, pw(1, 3, 32'h1), pw(1, 3, 32'h33), 3'd1, 1'b1, 32'h8};
    vecs[18] = '{a10, b11, pw(1, 13, 32'hD1), a10, b11, 3'd0, 1'b1, 32'h0};
    vecs[19] = '{a10, b11, pw(1, 14, 32'hD2), a10, b11, 3'd1, 1'b1, 32'h2000};
    vecs[20] = '{pw(1, 0, 32'hDEAD), n, n, pw(1, 13, 32'hD1), pw(1, 14, 32'hD2), 3'd2, 1'b1, 32'h6000};
    vecs[21] = '{n, n, pw(1, 0, 32'h55), n, n, 3'd0, 1'b1, 32'h0};
    vecs[22] = '{n, n, n, n, n, 3'd0, 1'b1, 32'h0};
    vecs[23] = '{a10, b11, pw(1, 20, 32'h1), a10, b11, 3'd0, 1'b1, 32'h0};
    vecs[24] = '{a10, b11, pw(1, 21, 32'h2), a10, b11, 3'd1, 1'b1, 32'h100000};
    vecs[25] = '{a10, b11, pw(1, 22, 32'h3), a10, b11, 3'd2, 1'b1, 32'h300000};

    // Reset held with live inputs: outputs must stay quiet.
    reset = 1'b0;
    drive(pw(1, 3, 32'h3), pw(1, 4, 32'h4), pw(1, 5, 32'h5));
    #2;
    chk("rst.w1", 64'(rfw[1][37]), 64'd0);
    chk("rst.w0", 64'(rfw[0][37]), 64'd0);
    chk("rst.rdy", 64'(l_ready), 64'd0);
    chk("rst.cnt", 64'(fifo_cnt), 64'd0);
    chk("rst.pend", 64'(pend_mask), 64'd0);
    @(negedge clk);
    drive(n, n, n);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 26; k++) run_vec(k, vecs[k]);

    chk("rf.r5", 64'(rf[5]), 64'h11);
    chk("rf.r7", 64'(rf[7]), 64'hBB);
    chk("rf.r9", 64'(rf[9]), 64'h99);
    chk("rf.r3", 64'(rf[3]), 64'h33);
    chk("rf.r4", 64'(rf[4]), 64'h104);

    // Reset arrives while three entries are queued and draining.
    @(negedge clk);
    drive(n, n, n);
    #1;
    chk("mid.cnt", 64'(fifo_cnt), 64'd3);
    chk("mid.pend", 64'(pend_mask), 64'h700000);
    chk_port("mid.rfw1", rfw[1], pw(1, 20, 32'h1));
    reset = 1'b0;
    #1;
    chk("mid.rst.cnt", 64'(fifo_cnt), 64'd0);
    chk("mid.rst.pend", 64'(pend_mask), 64'd0);
    chk("mid.rst.w1", 64'(rfw[1][37]), 64'd0);
    chk("mid.rst.w0", 64'(rfw[0][37]), 64'd0);
    chk("mid.rst.rdy", 64'(l_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post.cnt", 64'(fifo_cnt), 64'd0);
    chk("post.w1", 64'(rfw[1][37]), 64'd0);
    chk("post.w0", 64'(rfw[0][37]), 64'd0);
    chk("post.rdy", 64'(l_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
